// File: rtl/polygon_area_engine.sv
// Shoelace polygon area: collects NUM_VERT vertices, streams edge operands to an external cross unit, reports |sum|/2.
// Latency: out_valid NUM_VERT+2 cycles after last vertex accept (NUM_VERT+3 when CROSS_PIPE_EN is defined).
// Backpressure: in_ready high only while loading; low through CALC and DONE.
module polygon_area_engine #(
  parameter int NUM_VERT = 6,
  parameter int CW       = 11,
  parameter int RW       = 23,
  parameter int ACC_W    = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_x,
  input  logic [CW-1:0]    in_y,
  output logic [CW-1:0]    cx0,
  output logic [CW-1:0]    cy0,
  output logic [CW-1:0]    cx1,
  output logic [CW-1:0]    cy1,
  input  logic [RW-1:0]    cross_res,
  output logic             out_valid,
  output logic [ACC_W-2:0] area,
  output logic             area_half
);

  localparam int IW = (NUM_VERT > 1) ? $clog2(NUM_VERT) : 1;
  localparam int EW = $clog2(NUM_VERT + 1);
`ifdef CROSS_PIPE_EN
  localparam int CALC_LAST = NUM_VERT;
`else
  localparam int CALC_LAST = NUM_VERT - 1;
`endif
  localparam logic [IW-1:0] VLAST = IW'(NUM_VERT - 1);
  localparam logic [EW-1:0] ELAST = EW'(CALC_LAST);
  localparam logic [EW-1:0] ENUM  = EW'(NUM_VERT);

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } vert_t;

  typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;

  state_t           state;
  vert_t            v [NUM_VERT];
  logic [IW-1:0]    vcnt;
  logic [EW-1:0]    ecnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_abs;
  logic [ACC_W-1:0] res_ext;
  logic [IW-1:0]    cur_idx;
  logic [IW-1:0]    nxt_idx;
  logic             term_live;
  logic             add_en;
  logic             accept;

  // With a registered cross unit the result of term i lands one cycle later,
  // so the first CALC cycle carries no valid result.
`ifdef CROSS_PIPE_EN
  assign add_en = (ecnt != '0);
`else
  assign add_en = 1'b1;
`endif

  always_comb begin
    accept    = in_valid && in_ready && (state == LOAD);
    cur_idx   = ecnt[IW-1:0];
    nxt_idx   = (cur_idx == VLAST) ? '0 : cur_idx + IW'(1);
    term_live = (state == CALC) && (ecnt < ENUM);
    cx0 = '0;
    cy0 = '0;
    cx1 = '0;
    cy1 = '0;
    if (term_live) begin
      cx0 = v[cur_idx].x;
      cy0 = v[cur_idx].y;
      cx1 = v[nxt_idx].x;
      cy1 = v[nxt_idx].y;
    end
    res_ext = {{(ACC_W-RW){cross_res[RW-1]}}, cross_res};
    acc_abs = acc[ACC_W-1] ? ('0 - acc) : acc;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      v[vcnt] <= '{x: in_x, y: in_y};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      vcnt      <= '0;
      ecnt      <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      area      <= '0;
      area_half <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            if (vcnt == VLAST) begin
              vcnt     <= '0;
              ecnt     <= '0;
              acc      <= '0;
              in_ready <= 1'b0;
              state    <= CALC;
            end else begin
              vcnt <= vcnt + IW'(1);
            end
          end
        end
        CALC: begin
          if (add_en) begin
            acc <= acc + res_ext;
          end
          if (ecnt == ELAST) begin
            ecnt  <= '0;
            state <= DONE;
          end else begin
            ecnt <= ecnt + EW'(1);
          end
        end
        DONE: begin
          area      <= acc_abs[ACC_W-1:1];
          area_half <= acc_abs[0];
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= LOAD;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_polygon_area_engine.sv
// Bench for polygon_area_engine: models the external cross unit and scoreboards area results and latency.
module tb_polygon_area_engine;

  localparam int NV = 6;
  localparam int CW = 11;
  localparam int RW = 23;
  localparam int AW = 26;
`ifdef CROSS_PIPE_EN
  localparam int LAT = NV + 3;
`else
  localparam int LAT = NV + 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_x;
  logic [CW-1:0] in_y;
  logic [CW-1:0] cx0;
  logic [CW-1:0] cy0;
  logic [CW-1:0] cx1;
  logic [CW-1:0] cy1;
  logic [RW-1:0] cross_res;
  logic [RW-1:0] cross_comb;
  logic [RW-1:0] cross_q;
  logic          out_valid;
  logic [AW-2:0] area;
  logic          area_half;

  typedef struct {
    int area;
    bit half;
    int acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   px[NV];
  int   py[NV];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  polygon_area_engine #(.NUM_VERT(NV), .CW(CW), .RW(RW), .ACC_W(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .cx0(cx0), .cy0(cy0), .cx1(cx1), .cy1(cy1),
    .cross_res(cross_res), .out_valid(out_valid), .area(area), .area_half(area_half)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // External cross_calculator model
  always_comb begin
    longint p;
    p = longint'($signed(cx0)) * longint'($signed(cy1)) - longint'($signed(cy0)) * longint'($signed(cx1));
    cross_comb = p[RW-1:0];
  end

  always @(posedge clk) cross_q <= cross_comb;

`ifdef CROSS_PIPE_EN
  assign cross_res = cross_q;
`else
  assign cross_res = cross_comb;
`endif

  exp_t          mon_e;
  int            mon_lat;
  logic [AW-2:0] mon_ea;

  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL spurious_out_valid: out_valid=1 at cycle %0d, required 0 (no pending polygon)", cyc);
      end else begin
        mon_e   = sb.pop_front();
        mon_ea  = mon_e.area[AW-2:0];
        mon_lat = cyc - mon_e.acc_cyc + 1;
        checks++;
        if (area !== mon_ea) $display("FAIL sb_area: got %0d, required %0d", area, mon_ea);
        else passes++;
        checks++;
        if (area_half !== mon_e.half) $display("FAIL sb_area_half: got %b, required %b", area_half, mon_e.half);
        else passes++;
        checks++;
        if (mon_lat != LAT) $display("FAIL sb_latency: got %0d cycles, required %0d", mon_lat, LAT);
        else passes++;
      end
    end
  end

  task automatic send_poly(input int first, input int gap, input bit hold, input bit push, input int ea, input bit eh);
    int t;
    int acc_at;
    acc_at = 0;
    for (int i = first; i < NV; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_x = CW'(px[i]);
      in_y = CW'(py[i]);
      t = 0;
      while (in_ready !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (t >= 100) $display("FAIL accept_timeout vertex %0d: in_ready=%b after %0d cycles, required 1", i, in_ready, t);
      else passes++;
      acc_at = cyc + 1;
      @(posedge clk);
      #1;
    end
    if (!hold) in_valid = 1'b0;
    if (push) sb.push_back('{area: ea, half: eh, acc_cyc: acc_at});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) $display("FAIL drain: %0d results pending after %0d cycles, required 0", sb.size(), t);
    else passes++;
    @(negedge clk);
  endtask

  function automatic longint shoelace_abs();
    longint s;
    s = 0;
    for (int i = 0; i < NV; i++) begin
      s += longint'(px[i]) * longint'(py[(i+1)%NV]) - longint'(py[i]) * longint'(px[(i+1)%NV]);
    end
    return (s < 0) ? -s : s;
  endfunction

  task automatic set_hex();
    px = '{0, 2, 3, 2, 0, -1};
    py = '{0, 0, 2, 4, 4, 2};
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL %s_in_ready: got %b, required 1", tag, in_ready); else passes++;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL %s_out_valid: got %b, required 0", tag, out_valid); else passes++;
    checks++;
    if (area !== '0) $display("FAIL %s_area: got %0d, required 0", tag, area); else passes++;
    checks++;
    if (area_half !== 1'b0) $display("FAIL %s_area_half: got %b, required 0", tag, area_half); else passes++;
    checks++;
    if ({cx0, cy0, cx1, cy1} !== '0) $display("FAIL %s_operands: got %h %h %h %h, required 0", tag, cx0, cy0, cx1, cy1); else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("reset");
  endtask

  task automatic test_hexagon();
    logic [CW-1:0] e0x, e0y, e1x, e1y;
    set_hex();
    send_poly(0, 0, 1'b0, 1'b1, 12, 1'b0);
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      e0x = CW'(px[k]);
      e0y = CW'(py[k]);
      e1x = CW'(px[(k+1)%NV]);
      e1y = CW'(py[(k+1)%NV]);
      checks++;
      if ({cx0, cy0, cx1, cy1} !== {e0x, e0y, e1x, e1y})
        $display("FAIL hex_operands term %0d: got (%0d,%0d,%0d,%0d), required (%0d,%0d,%0d,%0d)", k,
                 $signed(cx0), $signed(cy0), $signed(cx1), $signed(cy1), $signed(e0x), $signed(e0y), $signed(e1x), $signed(e1y));
      else passes++;
      checks++;
      if (in_ready !== 1'b0) $display("FAIL hex_calc_in_ready term %0d: got %b, required 0", k, in_ready); else passes++;
    end
    drain();
  endtask

  task automatic test_reverse();
    px = '{-1, 0, 2, 3, 2, 0};
    py = '{2, 4, 4, 2, 0, 0};
    send_poly(0, 0, 1'b0, 1'b1, 12, 1'b0);
    drain();
  endtask

  task automatic test_half_area();
    px = '{0, 3, 0, 0, 0, 0};
    py = '{0, 0, 1, 1, 1, 1};
    send_poly(0, 0, 1'b0, 1'b1, 1, 1'b1);
    drain();
  endtask

  task automatic test_extremes();
    px = '{-1024, 1023, 1023, -1024, -1024, -1024};
    py = '{-1024, -1024, 1023, 1023, 1023, 1023};
    send_poly(0, 0, 1'b0, 1'b1, 4190209, 1'b0);
    drain();
  endtask

  task automatic test_bubbles_hold();
    int t;
    bit seen;
    set_hex();
    send_poly(0, 2, 1'b1, 1'b1, 12, 1'b0);
    in_x = CW'(px[0]);
    in_y = CW'(py[0]);
    in_valid = 1'b1;
    seen = 1'b0;
    t = 0;
    while (!seen && t < 30) begin
      @(negedge clk);
      t++;
      if (out_valid === 1'b1) seen = 1'b1;
      else begin
        checks++;
        if (in_ready !== 1'b0) $display("FAIL hold_in_ready cycle %0d: got %b, required 0", t, in_ready); else passes++;
      end
    end
    checks++;
    if (!seen) $display("FAIL hold_out_valid: out_valid=0 after %0d cycles, required 1", t); else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL hold_accept_in_out_valid_cycle: in_ready=%b, required 1", in_ready); else passes++;
    @(posedge clk);
    #1;
    send_poly(1, 0, 1'b0, 1'b1, 12, 1'b0);
    drain();
  endtask

  task automatic test_reset_abort();
    int nv;
    set_hex();
    send_poly(0, 0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("abort");
    nv = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid === 1'b1) nv++;
    end
    checks++;
    if (nv != 0) $display("FAIL abort_no_out_valid: got %0d pulses, required 0", nv); else passes++;
    send_poly(0, 0, 1'b0, 1'b1, 12, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    longint s;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < NV; i++) begin
        px[i] = int'($urandom_range(2047)) - 1024;
        py[i] = int'($urandom_range(2047)) - 1024;
      end
      s = shoelace_abs();
      send_poly(0, 0, 1'b0, 1'b1, int'(s >> 1), s[0]);
    end
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_hexagon();
    test_reverse();
    test_half_area();
    test_extremes();
    test_bubbles_hold();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) $display("FAIL final_scoreboard: %0d pending, required 0", sb.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
